// File: rtl/seq_sub_divider_pkg.sv
// Shared definitions for the iterative signed divider: FSM encoding,
// default operand width and the most-negative constant helper.
package seq_sub_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [63:0] most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/seq_sub_divider_div_step.sv
// One restoring shift-and-subtract step on magnitudes; the subtraction is
// WIDTH+1 bits so that |divisor| = 2**(WIDTH-1) is handled.
module seq_sub_divider_div_step
  import seq_sub_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH:0]   dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder stays below |divisor| <= 2**(WIDTH-1), so WIDTH bits hold it.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - dvs_i;
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_sub_divider.sv
// Iterative signed divider: magnitude restoring division over WIDTH cycles,
// sign fix-up, then results held under a valid/ready handshake.
module seq_sub_divider
  import seq_sub_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH:0]   dvs_sext;
  logic [WIDTH:0]   dvs_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  seq_sub_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (q_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // q_q starts as |dividend| and fills with quotient bits from the LSB as the
  // dividend bits shift out of the MSB into the step.
  always_comb begin
    dvd_abs  = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    dvs_sext = {divisor[WIDTH-1], divisor};
    dvs_abs  = dvs_sext[WIDTH] ? ('0 - dvs_sext) : dvs_sext;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_q_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_d    = dividend[WIDTH-1];
          q_d        = dvd_abs;
          rem_d      = '0;
          dvs_d      = dvs_abs;
          cnt_d      = CW'(WIDTH - 1);
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
          if (divisor == '0) begin
            div_zero_d  = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            state_d     = DONE;
          end else if (dividend == MOST_NEG && divisor == '1) begin
            overflow_d  = 1'b1;
            quotient_d  = MOST_NEG;
            remainder_d = '0;
            state_d     = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        q_d   = {q_q[WIDTH-2:0], step_qbit};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        quotient_d  = neg_q_q ? ('0 - q_q) : q_q;
        remainder_d = neg_r_q ? ('0 - rem_q) : rem_q;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
